// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage 16-bit pipeline: freezes, bubbles and flushes
// the pipeline registers, steers the PC and drains the pipeline into a sticky halt on HLT.
module pipeline_hazard_ctrl #(
  parameter int REG_BITS     = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] ID_rs1,
  input  logic [REG_BITS-1:0] ID_rs2,
  input  logic                ID_uses_rs1,
  input  logic                ID_uses_rs2,
  input  logic                ID_branch_taken,
  input  logic                ID_halt,
  input  logic                EX_memread,
  input  logic [REG_BITS-1:0] EX_rd,
  input  logic                imem_stall,
  input  logic                dmem_stall,
  output logic                PC_en,
  output logic                PC_sel_branch,
  output logic                IF_ID_en,
  output logic                IF_ID_flush,
  output logic                ID_EX_en,
  output logic                ID_EX_flush,
  output logic                EX_MEM_en,
  output logic                MEM_WB_en,
  output logic                halted
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic               r_redirectPend;
  logic               w_redirectPendNext;
  logic [CNT_W-1:0]   r_drainCnt;
  logic [CNT_W-1:0]   w_drainCntNext;
  logic               r_halted;
  logic               w_haltedNext;
  logic               w_loadUse;

  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign w_loadUse = EX_memread && (EX_rd != '0) &&
                     ((ID_uses_rs1 && (EX_rd == ID_rs1)) ||
                      (ID_uses_rs2 && (EX_rd == ID_rs2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_redirectPend <= 1'b0;
      r_drainCnt     <= '0;
      r_halted       <= 1'b0;
    end else begin
      r_state        <= w_stateNext;
      r_redirectPend <= w_redirectPendNext;
      r_drainCnt     <= w_drainCntNext;
      r_halted       <= w_haltedNext;
    end
  end

  always_comb begin
    PC_en              = 1'b0;
    PC_sel_branch      = 1'b0;
    IF_ID_en           = 1'b0;
    IF_ID_flush        = 1'b0;
    ID_EX_en           = 1'b0;
    ID_EX_flush        = 1'b0;
    EX_MEM_en          = 1'b0;
    MEM_WB_en          = 1'b0;
    halted             = 1'b0;
    w_stateNext        = r_state;
    w_redirectPendNext = r_redirectPend;
    w_drainCntNext     = r_drainCnt;
    w_haltedNext       = r_halted;

    if (!rst) begin
      halted = r_halted;
      unique case (r_state)
        ST_RUN: begin
          if (dmem_stall) begin
            // Full freeze; branch/HLT in ID simply wait.
          end else if (imem_stall) begin
            ID_EX_en  = 1'b1;
            EX_MEM_en = 1'b1;
            MEM_WB_en = 1'b1;
            if (w_loadUse) begin
              ID_EX_flush = 1'b1;
            end else begin
              // A HLT must stay in ID, so only feed a NOP into ID when no HLT sits there.
              IF_ID_en    = !ID_halt;
              IF_ID_flush = !ID_halt;
              if (ID_branch_taken) begin
                PC_en              = 1'b1;
                PC_sel_branch      = 1'b1;
                w_redirectPendNext = 1'b1;
              end
            end
          end else begin
            ID_EX_en  = 1'b1;
            EX_MEM_en = 1'b1;
            MEM_WB_en = 1'b1;
            if (w_loadUse) begin
              // ID/IF hold; a pending wrong-path discard is kept until IF/ID can be written.
              ID_EX_flush = 1'b1;
            end else begin
              IF_ID_en           = 1'b1;
              IF_ID_flush        = r_redirectPend;
              w_redirectPendNext = 1'b0;
              if (ID_branch_taken) begin
                PC_en         = 1'b1;
                PC_sel_branch = 1'b1;
                IF_ID_flush   = 1'b1;
              end else if (ID_halt) begin
                IF_ID_flush    = 1'b1;
                w_stateNext    = ST_DRAIN;
                w_drainCntNext = CNT_W'(DRAIN_CYCLES);
              end else begin
                PC_en = 1'b1;
              end
            end
          end
        end

        ST_DRAIN: begin
          IF_ID_en    = 1'b1;
          IF_ID_flush = 1'b1;
          if (!dmem_stall) begin
            ID_EX_en       = 1'b1;
            EX_MEM_en      = 1'b1;
            MEM_WB_en      = 1'b1;
            w_drainCntNext = r_drainCnt - 1'b1;
            if (r_drainCnt <= CNT_W'(1)) begin
              w_stateNext    = ST_HALTED;
              w_haltedNext   = 1'b1;
              w_drainCntNext = '0;
            end
          end
        end

        ST_HALTED: begin
          halted = 1'b1;
        end

        default: begin
          w_stateNext = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; outputs are packed as
// {PC_en, PC_sel_branch, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_en, halted}.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] ID_rs1;
  logic [3:0] ID_rs2;
  logic       ID_uses_rs1;
  logic       ID_uses_rs2;
  logic       ID_branch_taken;
  logic       ID_halt;
  logic       EX_memread;
  logic [3:0] EX_rd;
  logic       imem_stall;
  logic       dmem_stall;
  logic       PC_en;
  logic       PC_sel_branch;
  logic       IF_ID_en;
  logic       IF_ID_flush;
  logic       ID_EX_en;
  logic       ID_EX_flush;
  logic       EX_MEM_en;
  logic       MEM_WB_en;
  logic       halted;

  int totalChecks = 0;
  int badChecks   = 0;

  localparam logic [8:0] OUT_ZERO    = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] OUT_NORMAL  = 9'b1_0_1_0_1_0_1_1_0;
  localparam logic [8:0] OUT_LOADUSE = 9'b0_0_0_0_1_1_1_1_0;
  localparam logic [8:0] OUT_BRANCH  = 9'b1_1_1_1_1_0_1_1_0;
  localparam logic [8:0] OUT_IMEM    = 9'b0_0_1_1_1_0_1_1_0;
  localparam logic [8:0] OUT_IMEMHLT = 9'b0_0_0_0_1_0_1_1_0;
  localparam logic [8:0] OUT_REDIR   = 9'b1_0_1_1_1_0_1_1_0;
  localparam logic [8:0] OUT_DRAIN   = 9'b0_0_1_1_1_0_1_1_0;
  localparam logic [8:0] OUT_DRAINDM = 9'b0_0_1_1_0_0_0_0_0;
  localparam logic [8:0] OUT_HALTED  = 9'b0_0_0_0_0_0_0_0_1;

  pipeline_hazard_ctrl #(.REG_BITS(4), .DRAIN_CYCLES(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_uses_rs1     (ID_uses_rs1),
    .ID_uses_rs2     (ID_uses_rs2),
    .ID_branch_taken (ID_branch_taken),
    .ID_halt         (ID_halt),
    .EX_memread      (EX_memread),
    .EX_rd           (EX_rd),
    .imem_stall      (imem_stall),
    .dmem_stall      (dmem_stall),
    .PC_en           (PC_en),
    .PC_sel_branch   (PC_sel_branch),
    .IF_ID_en        (IF_ID_en),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_en        (ID_EX_en),
    .ID_EX_flush     (ID_EX_flush),
    .EX_MEM_en       (EX_MEM_en),
    .MEM_WB_en       (MEM_WB_en),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    ID_rs1          = 4'd0;
    ID_rs2          = 4'd0;
    ID_uses_rs1     = 1'b0;
    ID_uses_rs2     = 1'b0;
    ID_branch_taken = 1'b0;
    ID_halt         = 1'b0;
    EX_memread      = 1'b0;
    EX_rd           = 4'd0;
    imem_stall      = 1'b0;
    dmem_stall      = 1'b0;
  endtask

  // Inputs are set just after a rising edge; outputs are sampled mid-cycle, then the edge is taken.
  task automatic applyStimulus(input string tag, input logic [8:0] expected);
    #3;
    checkOutput(tag, {PC_en, PC_sel_branch, IF_ID_en, IF_ID_flush, ID_EX_en,
                      ID_EX_flush, EX_MEM_en, MEM_WB_en, halted}, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic loadUseRs2(input logic [3:0] rd);
    clearInputs();
    EX_memread  = 1'b1;
    EX_rd       = rd;
    ID_rs2      = rd;
    ID_uses_rs2 = 1'b1;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    applyStimulus("rst_pulse", OUT_ZERO);
    rst = 1'b0;
    applyStimulus("rst_release", OUT_NORMAL);
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    @(posedge clk);
    #1;

    // Reset with every input active
    ID_rs1 = 4'd3; ID_rs2 = 4'd3; EX_rd = 4'd3;
    ID_uses_rs1 = 1'b1; ID_uses_rs2 = 1'b1; ID_branch_taken = 1'b1; ID_halt = 1'b1;
    EX_memread = 1'b1; imem_stall = 1'b1; dmem_stall = 1'b1;
    applyStimulus("rst_hold0", OUT_ZERO);
    applyStimulus("rst_hold1", OUT_ZERO);
    clearInputs();
    rst = 1'b0;
    applyStimulus("after_rst", OUT_NORMAL);

    // Load-use on rs2, then on rs1, then the non-hazard variants
    loadUseRs2(4'd3);
    applyStimulus("lu_rs2", OUT_LOADUSE);
    clearInputs();
    applyStimulus("lu_release", OUT_NORMAL);
    clearInputs();
    EX_memread = 1'b1; EX_rd = 4'd7; ID_rs1 = 4'd7; ID_uses_rs1 = 1'b1;
    applyStimulus("lu_rs1", OUT_LOADUSE);
    loadUseRs2(4'd0);
    applyStimulus("lu_r0", OUT_NORMAL);
    loadUseRs2(4'd3);
    ID_uses_rs2 = 1'b0;
    applyStimulus("lu_unused", OUT_NORMAL);
    loadUseRs2(4'd3);
    EX_memread = 1'b0;
    applyStimulus("lu_noload", OUT_NORMAL);
    loadUseRs2(4'd3);
    ID_branch_taken = 1'b1; ID_halt = 1'b1;
    applyStimulus("lu_over_br", OUT_LOADUSE);

    // Plain taken branch
    clearInputs();
    ID_branch_taken = 1'b1;
    applyStimulus("branch", OUT_BRANCH);

    // Branch during a 3-cycle imem stall, then the wrong-path discard
    clearInputs();
    imem_stall = 1'b1; ID_branch_taken = 1'b1;
    applyStimulus("imem_br_c1", OUT_BRANCH);
    ID_branch_taken = 1'b0;
    applyStimulus("imem_br_c2", OUT_IMEM);
    applyStimulus("imem_br_c3", OUT_IMEM);
    imem_stall = 1'b0;
    applyStimulus("redir_flush", OUT_REDIR);
    applyStimulus("redir_done", OUT_NORMAL);

    // Redirect pending while a new branch resolves in ID
    imem_stall = 1'b1; ID_branch_taken = 1'b1;
    applyStimulus("imem_br2", OUT_BRANCH);
    imem_stall = 1'b0;
    applyStimulus("redir_br", OUT_BRANCH);
    ID_branch_taken = 1'b0;
    applyStimulus("redir_br_done", OUT_NORMAL);

    // imem stall combined with load-use and with HLT
    loadUseRs2(4'd5);
    imem_stall = 1'b1;
    applyStimulus("imem_lu", OUT_LOADUSE);
    clearInputs();
    imem_stall = 1'b1; ID_halt = 1'b1;
    applyStimulus("imem_hlt", OUT_IMEMHLT);

    // dmem stall outranks everything else
    loadUseRs2(4'd3);
    imem_stall = 1'b1; ID_branch_taken = 1'b1; dmem_stall = 1'b1;
    applyStimulus("dmem_prio", OUT_ZERO);
    dmem_stall = 1'b0;
    applyStimulus("dmem_drop", OUT_LOADUSE);
    clearInputs();
    applyStimulus("dmem_after", OUT_NORMAL);

    // HLT drain with no stalls: halted visible 4 samples after the HLT cycle
    clearInputs();
    ID_halt = 1'b1;
    applyStimulus("hlt_enter", OUT_DRAIN);
    clearInputs();
    applyStimulus("drain1", OUT_DRAIN);
    imem_stall = 1'b1; ID_branch_taken = 1'b1;
    applyStimulus("drain2_ign", OUT_DRAIN);
    clearInputs();
    applyStimulus("drain3", OUT_DRAIN);
    applyStimulus("halted0", OUT_HALTED);
    ID_branch_taken = 1'b1; imem_stall = 1'b1;
    applyStimulus("halted1", OUT_HALTED);
    loadUseRs2(4'd2);
    applyStimulus("halted2", OUT_HALTED);
    doReset();

    // HLT drain with one dmem stall cycle in the middle
    clearInputs();
    ID_halt = 1'b1;
    applyStimulus("hltd_enter", OUT_DRAIN);
    clearInputs();
    applyStimulus("hltd_1", OUT_DRAIN);
    dmem_stall = 1'b1;
    applyStimulus("hltd_dm", OUT_DRAINDM);
    dmem_stall = 1'b0;
    applyStimulus("hltd_2", OUT_DRAIN);
    applyStimulus("hltd_3", OUT_DRAIN);
    applyStimulus("hltd_halted", OUT_HALTED);
    applyStimulus("hltd_sticky", OUT_HALTED);
    doReset();

    // Reset while the drain counter sits at 2
    clearInputs();
    ID_halt = 1'b1;
    applyStimulus("mid_enter", OUT_DRAIN);
    clearInputs();
    applyStimulus("mid_drain1", OUT_DRAIN);
    rst = 1'b1;
    applyStimulus("mid_rst", OUT_ZERO);
    rst = 1'b0;
    applyStimulus("mid_run0", OUT_NORMAL);
    applyStimulus("mid_run1", OUT_NORMAL);
    applyStimulus("mid_run2", OUT_NORMAL);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
